seg7_mux_driver: RTL and testbench
==================================

# seg7_mux_driver

Two-digit multiplexed seven-segment driver sitting directly downstream of the I2C target in the `rp2_ice_i2c_7seg` design. It latches each byte written over I2C, hex-decodes both nibbles, and time-multiplexes them onto the shared segment bus with a select line. A blanking dead-time precedes every digit switch to suppress ghosting. It owns `seg_pins_o`/`seg_select_o` at the `main` boundary.

## Interface
- `REFRESH_CYCLES`, 1000: clock cycles per digit slot, dead-time included; must be ≥ 2 and > `DEAD_CYCLES`.
- `DEAD_CYCLES`, 16: blanked cycles at the end of each slot; 0 disables dead-time.
- `SEG_ACTIVE_HIGH`, 1: 1 means a lit segment is driven 1; 0 inverts all of `seg_pins_o`, including the blank pattern.

- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `data_i` in 8: byte from the I2C target.
- `data_valid_i` in 1: one-cycle strobe; `data_i` is captured on that edge.
- `seg_pins_o` out 7: segments a..g on bits 0..6, registered.
- `seg_select_o` out 1: 0 selects the low-nibble digit, 1 the high-nibble digit; registered.

## Operation
- Data register `data_q`, 8 bits, reset 0x00.
  - Loaded from `data_i` on every edge where `data_valid_i` = 1.
  - No handshake back to the source; back-to-back strobes each overwrite, last one wins.
- Nibble select: `seg_select_o` = 0 shows `data_q[3:0]`; 1 shows `data_q[7:4]`.
- Hex decode, active-high form, bit 6..0 = g..a:
  - 0→0x3F, 1→0x06, 2→0x5B, 3→0x4F, 4→0x66, 5→0x6D, 6→0x7D, 7→0x07
  - 8→0x7F, 9→0x6F, A→0x77, b→0x7C, C→0x39, d→0x5E, E→0x79, F→0x71
- State machine, two states:
  - SHOW: segments driven with the decoded nibble. Stays for `REFRESH_CYCLES-DEAD_CYCLES` cycles, then goes to DEAD. If `DEAD_CYCLES` = 0, it toggles `seg_select_o` and re-enters SHOW instead.
  - DEAD: segments at the blank pattern, select unchanged. Stays for `DEAD_CYCLES` cycles, then toggles `seg_select_o` and goes to SHOW.
- Slot counter:
  - Width `$clog2(REFRESH_CYCLES)`.
  - Counts 0..`REFRESH_CYCLES-1` and wraps to 0 on the select toggle.
  - The state is derived from a compare against `REFRESH_CYCLES-DEAD_CYCLES`.
- Segment register: recomputed every cycle from the current state, select and `data_q`. A byte captured mid-SHOW therefore updates the lit digit without waiting for the next slot.
- Blank pattern: 0x00 when `SEG_ACTIVE_HIGH` = 1, 0x7F when it is 0.

## Timing
- Reset values (asynchronous, immediate, including mid-slot):
  - `seg_pins_o` = blank pattern, `seg_select_o` = 0.
  - State SHOW, counter 0, `data_q` = 0x00.
- After reset release: first edge loads the counter/state; `seg_pins_o` shows the decode of 0x0 (0x3F) from the second edge.
- Capture latency:
  - `data_valid_i` at edge N → `data_q` valid after N.
  - `seg_pins_o` reflects it after edge N+1, provided the state is SHOW.
- Select period: exactly `REFRESH_CYCLES` cycles per level. Full frame is 2·`REFRESH_CYCLES`.
- Segment/select alignment:
  - `seg_pins_o` is blank on the same edge the state enters DEAD.
  - It leaves blank on the edge after select toggles, so select never changes while segments are lit (when `DEAD_CYCLES` ≥ 1).
- Strobe during DEAD: captured normally; shown at the next SHOW.

## Configuration
- `SEG7_ZERO_BLANK_EN` defined:
  - High digit (`seg_select_o` = 1) is driven blank during SHOW whenever `data_q[7:4]` = 0 (leading-zero suppression).
  - The low digit always shows.
- `SEG7_ZERO_BLANK_EN` undefined: high digit shows '0' (0x3F).
- Slot timing is identical in both builds.

## Test plan
- Reset/idle, `REFRESH_CYCLES`=8, `DEAD_CYCLES`=2:
  - `rst_n` low → `seg_pins_o`=0x00, `seg_select_o`=0.
  - After release, select toggles every 8 cycles.
  - Segments are 0x3F for 6 cycles, then 0x00 for 2, per slot.
- Write 0xA5 via one-cycle strobe:
  - select=0 slots show 0x6D; select=1 slots show 0x77.
  - First change visible 2 edges after the strobe edge.
- Strobes 0x12 then 0x34 back-to-back → display shows 0x34 only (4→0x66, 3→0x4F); 0x12 is never displayed in SHOW.
- Strobe 0x0F issued during DEAD → segments stay blank until the select toggle, then show 0x71 on the select=0 slot.
  - With `SEG7_ZERO_BLANK_EN` defined: select=1 slot is blank.
  - Without it: select=1 slot shows 0x3F.
- Assert `rst_n` mid-SHOW with `data_q`=0x88 → same cycle `seg_pins_o`=0x00, select=0; after release the display shows 0x3F (`data_q` cleared).
- `SEG_ACTIVE_HIGH`=0, `DEAD_CYCLES`=0, data 0x08 → low digit drives 0x00 (inverted 0x7F), high digit 0x40 (inverted 0x3F); no blank cycles between slots.

Source files
------------

// File: rtl/seg7_mux_driver.sv
// Two-digit multiplexed seven-segment driver: latches a byte, hex-decodes both nibbles,
// alternates them on a shared segment bus with a blanking dead-time before each digit switch.
// Optional build macro SEG7_ZERO_BLANK_EN blanks the high digit when its nibble is zero.
module seg7_mux_driver #(
    parameter int REFRESH_CYCLES  = 1000,
    parameter int DEAD_CYCLES     = 16,
    parameter bit SEG_ACTIVE_HIGH = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] data_i,
    input  logic       data_valid_i,
    output logic [6:0] seg_pins_o,
    output logic       seg_select_o
);
    localparam int CNT_W       = $clog2(REFRESH_CYCLES);
    localparam int SHOW_CYCLES = REFRESH_CYCLES - DEAD_CYCLES;
    localparam int LAST        = REFRESH_CYCLES - 1;

    localparam logic [CNT_W:0]   SHOW_LIMIT  = SHOW_CYCLES[CNT_W:0];
    localparam logic [CNT_W-1:0] LAST_COUNT  = LAST[CNT_W-1:0];
    localparam logic [6:0]       INVERT_MASK = SEG_ACTIVE_HIGH ? 7'h00 : 7'h7F;

    typedef enum logic {
        SHOW = 1'b0,
        DEAD = 1'b1
    } state_e;

    logic [7:0]       data_q, data_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             select_q, select_d;
    logic             started_q, started_d;
    logic [6:0]       seg_q, seg_d;
    logic [3:0]       nibble;
    logic [6:0]       lit;
    state_e           state;

    function automatic logic [6:0] hex_decode(input logic [3:0] value);
        logic [6:0] segs;
        case (value)
            4'h0: segs = 7'h3F;
            4'h1: segs = 7'h06;
            4'h2: segs = 7'h5B;
            4'h3: segs = 7'h4F;
            4'h4: segs = 7'h66;
            4'h5: segs = 7'h6D;
            4'h6: segs = 7'h7D;
            4'h7: segs = 7'h07;
            4'h8: segs = 7'h7F;
            4'h9: segs = 7'h6F;
            4'hA: segs = 7'h77;
            4'hB: segs = 7'h7C;
            4'hC: segs = 7'h39;
            4'hD: segs = 7'h5E;
            4'hE: segs = 7'h79;
            default: segs = 7'h71;
        endcase
        return segs;
    endfunction

    // With no dead-time SHOW_LIMIT equals REFRESH_CYCLES, so the slot never reaches DEAD.
    always_comb begin
        data_d    = data_valid_i ? data_i : data_q;
        started_d = 1'b1;
        count_d   = count_q + CNT_W'(1);
        select_d  = select_q;
        if (count_q == LAST_COUNT) begin
            count_d  = '0;
            select_d = ~select_q;
        end
        state = ({1'b0, count_q} >= SHOW_LIMIT) ? DEAD : SHOW;
    end

    // Decode follows the select level being registered this edge, so a digit and its select
    // always appear together; the first edge after reset only primes the slot timing.
    always_comb begin
        nibble = select_d ? data_q[7:4] : data_q[3:0];
        lit    = hex_decode(nibble);
`ifdef SEG7_ZERO_BLANK_EN
        if (select_d && (data_q[7:4] == 4'h0)) begin
            lit = 7'h00;
        end
`endif
        if (!started_q || state == DEAD) begin
            lit = 7'h00;
        end
        seg_d = lit ^ INVERT_MASK;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q    <= 8'h00;
            count_q   <= '0;
            select_q  <= 1'b0;
            started_q <= 1'b0;
            seg_q     <= INVERT_MASK;
        end else begin
            data_q    <= data_d;
            count_q   <= count_d;
            select_q  <= select_d;
            started_q <= started_d;
            seg_q     <= seg_d;
        end
    end

    assign seg_pins_o   = seg_q;
    assign seg_select_o = select_q;

endmodule

// File: tb/tb_seg7_mux_driver.sv
// Scoreboard bench for seg7_mux_driver: a main instance (8-cycle slots, 2 dead) and an
// inverted-polarity instance with no dead-time; expectations are queued and checked at negedge.
module tb_seg7_mux_driver;

`ifdef SEG7_ZERO_BLANK_EN
    localparam logic [6:0] HI_ZERO     = 7'h00;
    localparam logic [6:0] HI_ZERO_INV = 7'h7F;
`else
    localparam logic [6:0] HI_ZERO     = 7'h3F;
    localparam logic [6:0] HI_ZERO_INV = 7'h40;
`endif

    typedef struct {
        logic [6:0] seg;
        logic       sel;
        int         idx;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] data_i = 8'h00;
    logic       data_valid_i = 1'b0;
    logic [6:0] seg_pins_o;
    logic       seg_select_o;

    logic [7:0] data2_i = 8'h00;
    logic       data2_valid_i = 1'b0;
    logic [6:0] seg2_pins_o;
    logic       seg2_select_o;

    exp_t main_q[$];
    exp_t alt_q[$];
    int   checks = 0;
    int   failures = 0;
    int   step_no = 0;

    logic       arm_valid = 1'b0;
    logic [7:0] arm_data = 8'h00;
    logic       arm_rst = 1'b0;

    always #5 clk = ~clk;

    seg7_mux_driver #(
        .REFRESH_CYCLES (8),
        .DEAD_CYCLES    (2),
        .SEG_ACTIVE_HIGH(1'b1)
    ) u_dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .data_i      (data_i),
        .data_valid_i(data_valid_i),
        .seg_pins_o  (seg_pins_o),
        .seg_select_o(seg_select_o)
    );

    seg7_mux_driver #(
        .REFRESH_CYCLES (4),
        .DEAD_CYCLES    (0),
        .SEG_ACTIVE_HIGH(1'b0)
    ) u_dut_inv (
        .clk         (clk),
        .rst_n       (rst_n),
        .data_i      (data2_i),
        .data_valid_i(data2_valid_i),
        .seg_pins_o  (seg2_pins_o),
        .seg_select_o(seg2_select_o)
    );

    task automatic checkOutput(input string name, input exp_t e,
                               input logic [6:0] seg, input logic sel);
        checks++;
        if (seg !== e.seg || sel !== e.sel) begin
            failures++;
            $display("[TB] FAIL %s step=%0d got seg=%h sel=%b required seg=%h sel=%b",
                     name, e.idx, seg, sel, e.seg, e.sel);
        end
    endtask

    always @(negedge clk) begin
        if (main_q.size() > 0) checkOutput("main", main_q.pop_front(), seg_pins_o, seg_select_o);
        if (alt_q.size() > 0) checkOutput("inv_nodead", alt_q.pop_front(), seg2_pins_o, seg2_select_o);
    end

    // One clock edge: queue what the outputs must show after it, then drive the armed inputs.
    task automatic applyStimulus(input logic [6:0] seg, input logic sel);
        exp_t e;
        @(posedge clk);
        step_no++;
        e.seg = seg;
        e.sel = sel;
        e.idx = step_no;
        main_q.push_back(e);
        #1;
        data_valid_i = arm_valid;
        data_i       = arm_data;
        arm_valid    = 1'b0;
        rst_n        = arm_rst;
    endtask

    task automatic arm(input logic [7:0] d);
        arm_valid = 1'b1;
        arm_data  = d;
    endtask

    task automatic run_window(input logic [6:0] lit, input logic sel);
        repeat (6) applyStimulus(lit, sel);
        applyStimulus(7'h00, sel);
        applyStimulus(7'h00, ~sel);
    endtask

    task automatic first_window();
        applyStimulus(7'h00, 1'b0);
        repeat (5) applyStimulus(7'h3F, 1'b0);
        applyStimulus(7'h00, 1'b0);
        applyStimulus(7'h00, 1'b1);
    endtask

    initial begin
        applyStimulus(7'h00, 1'b0);
        applyStimulus(7'h00, 1'b0);
        arm_rst = 1'b1;
        applyStimulus(7'h00, 1'b0);

        first_window();
        run_window(HI_ZERO, 1'b1);

        arm(8'hA5);
        applyStimulus(7'h3F, 1'b0);
        applyStimulus(7'h3F, 1'b0);
        repeat (4) applyStimulus(7'h6D, 1'b0);
        applyStimulus(7'h00, 1'b0);
        applyStimulus(7'h00, 1'b1);
        run_window(7'h77, 1'b1);

        // Back-to-back strobes land in the dead-time, so 0x12 is never lit.
        repeat (5) applyStimulus(7'h6D, 1'b0);
        arm(8'h12);
        applyStimulus(7'h6D, 1'b0);
        arm(8'h34);
        applyStimulus(7'h00, 1'b0);
        applyStimulus(7'h00, 1'b1);
        run_window(7'h4F, 1'b1);

        repeat (5) applyStimulus(7'h66, 1'b0);
        arm(8'h0F);
        applyStimulus(7'h66, 1'b0);
        applyStimulus(7'h00, 1'b0);
        applyStimulus(7'h00, 1'b1);
        run_window(HI_ZERO, 1'b1);

        repeat (6) applyStimulus(7'h71, 1'b0);
        applyStimulus(7'h00, 1'b0);
        arm(8'h88);
        applyStimulus(7'h00, 1'b1);

        applyStimulus(HI_ZERO, 1'b1);
        applyStimulus(7'h7F, 1'b1);
        arm_rst = 1'b0;
        applyStimulus(7'h00, 1'b0);
        applyStimulus(7'h00, 1'b0);
        arm_rst = 1'b1;
        applyStimulus(7'h00, 1'b0);

        first_window();
        run_window(HI_ZERO, 1'b1);

        for (int i = 0; i < 20 && (main_q.size() > 0 || alt_q.size() > 0); i++) begin
            @(negedge clk);
        end
        @(posedge clk);
        if (main_q.size() > 0 || alt_q.size() > 0) begin
            failures++;
            $display("[TB] FAIL drain got pending=%0d required pending=0",
                     main_q.size() + alt_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Inverted polarity, no dead-time: 0x08 gives low digit 0x00 and high digit 0x40.
    initial begin
        logic [6:0] alt_seg [12];
        logic       alt_sel [12];
        exp_t       e;
        alt_seg = '{7'h7F, 7'h00, 7'h00, HI_ZERO_INV, HI_ZERO_INV, HI_ZERO_INV, HI_ZERO_INV,
                    7'h00, 7'h00, 7'h00, 7'h00, HI_ZERO_INV};
        alt_sel = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        @(posedge clk);
        e.seg = 7'h7F;
        e.sel = 1'b0;
        e.idx = 0;
        alt_q.push_back(e);
        @(posedge rst_n);
        data2_i       = 8'h08;
        data2_valid_i = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk);
            e.seg = alt_seg[i];
            e.sel = alt_sel[i];
            e.idx = i + 1;
            alt_q.push_back(e);
            #1;
            data2_valid_i = 1'b0;
        end
    end

endmodule
